// File: rtl/div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done
// handshake, registered quotient/remainder and divide-by-zero flag.
module div_seq #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         div_zero_o
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  // R is kept N bits: the partial remainder is always < D, so its (N+1)-th bit is
  // only ever non-zero transiently inside the shifted value below.
  logic [N-1:0]  r_q, q_q, d_q;
  logic [N:0]    r_sh, t;
  logic [N-1:0]  r_nxt, q_nxt;
  logic          accept, last;

  always_comb begin
    r_sh  = {r_q, q_q[N-1]};
    t     = r_sh - {1'b0, d_q};
    r_nxt = t[N] ? r_sh[N-1:0] : t[N-1:0];
    q_nxt = {q_q[N-2:0], ~t[N]};
  end

  assign accept = start_i && (state != CALC);
  assign last   = (cnt == CW'(N - 1));
  assign busy_o = (state == CALC);
  assign done_o = (state == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start_i) state_nxt = (divisor_i == '0) ? DONE : CALC;
        else         state_nxt = IDLE;
      end
      CALC:    if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt         <= '0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else if (accept) begin
      if (divisor_i == '0) begin
        quotient_o  <= '1;
        remainder_o <= dividend_i;
        div_zero_o  <= 1'b1;
      end else begin
        d_q <= divisor_i;
        q_q <= dividend_i;
        r_q <= '0;
        cnt <= '0;
      end
    end else if (state == CALC) begin
      r_q <= r_nxt;
      q_q <= q_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        quotient_o  <= q_nxt;
        remainder_o <= r_nxt;
        div_zero_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table, handshake corner sequences and a
// randomized/exhaustive sweep against plain-arithmetic division.
module tb_div_seq;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_i, start_i;
  logic [N-1:0] dividend_i, divisor_i;
  logic         busy_o, done_o, div_zero_o;
  logic [N-1:0] quotient_o, remainder_o;

  int total = 0;
  int bad   = 0;

  div_seq #(.N(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .quotient_o (quotient_o),
    .remainder_o(remainder_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a, b, eq, er, ez;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference: plain unsigned division, divide-by-zero returns all ones / dividend.
  task automatic model(input int a, input int b, output int q, output int r,
                       output int z, output int lat);
    if (b == 0) begin
      q = (1 << N) - 1; r = a; z = 1; lat = 1;
    end else begin
      q = a / b; r = a % b; z = 0; lat = N + 1;
    end
  endtask

  // Issue one operation and wait (bounded) for done_o; lat counts cycles after accept.
  task automatic run_op(input int a, input int b, output int q, output int r,
                        output int z, output int lat, output int busy_cnt);
    start_i    = 1'b1;
    dividend_i = N'(a);
    divisor_i  = N'(b);
    tick();
    start_i  = 1'b0;
    lat      = 999;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done_o) begin
        lat = i;
        break;
      end
      if (busy_o) busy_cnt++;
      tick();
    end
    q = int'(quotient_o);
    r = int'(remainder_o);
    z = int'(div_zero_o);
  endtask

  initial begin
    vec_t vecs[$];
    int q, r, z, lat, bc, eq, er, ez, elat, dones;

    vecs.push_back('{13, 3, 4, 1, 0});
    vecs.push_back('{15, 1, 15, 0, 0});
    vecs.push_back('{3, 9, 0, 3, 0});
    vecs.push_back('{15, 15, 1, 0, 0});
    vecs.push_back('{0, 5, 0, 0, 0});
    vecs.push_back('{7, 0, 15, 7, 1});
    vecs.push_back('{8, 2, 4, 0, 0});

    rst_i = 1'b1; start_i = 1'b0; dividend_i = '0; divisor_i = '0;
    tick(); tick();
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_quot", quotient_o, 0);
    check("rst_rem", remainder_o, 0);
    check("rst_dz", div_zero_o, 0);
    rst_i = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, q, r, z, lat, bc);
      check($sformatf("vec%0d_quot", i), q, vecs[i].eq);
      check($sformatf("vec%0d_rem", i), r, vecs[i].er);
      check($sformatf("vec%0d_dz", i), z, vecs[i].ez);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].ez ? 1 : N + 1);
      check($sformatf("vec%0d_busy", i), bc, vecs[i].ez ? 0 : N);
      check($sformatf("vec%0d_busy_at_done", i), busy_o, 0);
    end
    tick(); tick();
    check("idle_done_low", done_o, 0);

    // start pulsed during CALC must be ignored
    start_i = 1'b1; dividend_i = 4'd13; divisor_i = 4'd3;
    tick();
    start_i = 1'b0;
    tick();
    start_i = 1'b1; dividend_i = 4'd9; divisor_i = 4'd2;
    tick();
    start_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_o) begin
        dones++;
        check("ign_quot", quotient_o, 4);
        check("ign_rem", remainder_o, 1);
      end
      tick();
    end
    check("ign_done_count", dones, 1);

    // reset in 2nd CALC cycle aborts without a done pulse
    start_i = 1'b1; dividend_i = 4'd14; divisor_i = 4'd4;
    tick();
    start_i = 1'b0;
    tick();
    check("abort_busy_before", busy_o, 1);
    rst_i = 1'b1;
    #1;
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_quot", quotient_o, 0);
    check("abort_rem", remainder_o, 0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_o) dones++;
    end
    rst_i = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      tick();
      if (done_o) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(14, 4, q, r, z, lat, bc);
    check("after_abort_quot", q, 3);
    check("after_abort_rem", r, 2);

    // back-to-back: accept 11/5 in the done cycle of 9/2
    tick(); tick();
    run_op(9, 2, q, r, z, lat, bc);
    check("b2b_first_quot", q, 4);
    check("b2b_first_rem", r, 1);
    start_i = 1'b1; dividend_i = 4'd11; divisor_i = 4'd5;
    tick();
    start_i = 1'b0;
    lat = 999;
    for (int i = 1; i <= 40; i++) begin
      if (done_o) begin
        lat = i;
        break;
      end
      check("b2b_hold_quot", quotient_o, 4);
      check("b2b_hold_rem", remainder_o, 1);
      tick();
    end
    check("b2b_lat", lat, N + 1);
    check("b2b_second_quot", quotient_o, 2);
    check("b2b_second_rem", remainder_o, 1);

    // exhaustive sweep in random order, with random idle gaps
    begin
      int order[256];
      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
        int j, tmp;
        j = int'($urandom_range(i, 0));
        tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < 256; i++) begin
        int a, b;
        a = order[i] >> N;
        b = order[i] & ((1 << N) - 1);
        if ($urandom_range(3, 0) == 0) tick();
        model(a, b, eq, er, ez, elat);
        run_op(a, b, q, r, z, lat, bc);
        check($sformatf("sweep_%0d/%0d_quot", a, b), q, eq);
        check($sformatf("sweep_%0d/%0d_rem", a, b), r, er);
        check($sformatf("sweep_%0d/%0d_dz", a, b), z, ez);
        check($sformatf("sweep_%0d/%0d_lat", a, b), lat, elat);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
